// File: rtl/axis_packet_summer.sv
// Per-packet byte-masked modulo sum and beat counter on an AXI-Stream input.
// Each packet produces a two-beat result packet: the sum, then the beat count.
module axis_packet_summer #(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                    axis_aclk,
  input  logic                    axis_areset,
  input  logic [DATA_WIDTH-1:0]   s03_axis_rd_tdata,
  input  logic [DATA_WIDTH/8-1:0] s03_axis_tstrb,
  input  logic                    s03_axis_tvalid,
  input  logic                    s03_axis_tlast,
  output logic                    s03_axis_tready,
  output logic [DATA_WIDTH-1:0]   m03_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m03_axis_tstrb,
  output logic                    m03_axis_tvalid,
  output logic                    m03_axis_tlast,
  input  logic                    m03_axis_tready,
  output logic                    busy,
  output logic                    count_overflow
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    ACCUM    = 2'd0,
    SEND_SUM = 2'd1,
    SEND_CNT = 2'd2
  } state_t;

  state_t                  state, state_next;
  logic [DATA_WIDTH-1:0]   sum, sum_next, masked_data, tdata_next;
  logic [STRB_WIDTH-1:0]   tstrb_next;
  logic [COUNT_WIDTH-1:0]  count, count_next;
  logic                    overflow_next, tvalid_next, tlast_next, busy_next;
  logic                    accept;

  assign s03_axis_tready = !axis_areset && (state == ACCUM);
  assign accept          = s03_axis_tvalid && s03_axis_tready;

  always_comb begin
    masked_data = '0;
    for (int i = 0; i < STRB_WIDTH; i++) begin
      masked_data[i*8 +: 8] = s03_axis_tstrb[i] ? s03_axis_rd_tdata[i*8 +: 8] : 8'h00;
    end
  end

  always_comb begin
    state_next    = state;
    sum_next      = sum;
    count_next    = count;
    overflow_next = count_overflow;
    tdata_next    = m03_axis_tdata;
    tstrb_next    = m03_axis_tstrb;
    tvalid_next   = m03_axis_tvalid;
    tlast_next    = m03_axis_tlast;
    case (state)
      ACCUM: begin
        if (accept) begin
          sum_next = sum + masked_data;
          // counter saturates at all-ones rather than wrapping
          if (&count) overflow_next = 1'b1;
          else        count_next    = count + COUNT_WIDTH'(1);
          if (s03_axis_tlast) begin
            state_next  = SEND_SUM;
            tdata_next  = sum + masked_data;
            tstrb_next  = '1;
            tvalid_next = 1'b1;
            tlast_next  = 1'b0;
          end
        end
      end
      SEND_SUM: begin
        if (m03_axis_tready) begin
          state_next = SEND_CNT;
          tdata_next = DATA_WIDTH'(count);
          tlast_next = 1'b1;
        end
      end
      SEND_CNT: begin
        if (m03_axis_tready) begin
          state_next  = ACCUM;
          tvalid_next = 1'b0;
          tlast_next  = 1'b0;
          tstrb_next  = '0;
          tdata_next  = '0;
          sum_next    = '0;
          count_next  = '0;
        end
      end
      default: state_next = ACCUM;
    endcase
    busy_next = (state_next != ACCUM) || (count_next != '0);
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      state           <= ACCUM;
      sum             <= '0;
      count           <= '0;
      count_overflow  <= 1'b0;
      m03_axis_tdata  <= '0;
      m03_axis_tstrb  <= '0;
      m03_axis_tvalid <= 1'b0;
      m03_axis_tlast  <= 1'b0;
      busy            <= 1'b0;
    end else begin
      state           <= state_next;
      sum             <= sum_next;
      count           <= count_next;
      count_overflow  <= overflow_next;
      m03_axis_tdata  <= tdata_next;
      m03_axis_tstrb  <= tstrb_next;
      m03_axis_tvalid <= tvalid_next;
      m03_axis_tlast  <= tlast_next;
      busy            <= busy_next;
    end
  end

endmodule

// File: tb/tb_axis_packet_summer.sv
// Bench for axis_packet_summer: directed packets with literal expectations,
// then randomized traffic checked every cycle against a packet-level model.
module tb_axis_packet_summer;
  localparam int DW   = 32;
  localparam int CW   = 2;  // narrow counter so saturation is reachable
  localparam int SW   = DW / 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_data = '0;
  logic [SW-1:0] s_strb = '0;
  logic          s_valid = 1'b0, s_last = 1'b0, s_ready;
  logic [DW-1:0] m_data;
  logic [SW-1:0] m_strb;
  logic          m_valid, m_last, m_ready;
  logic          busy, ovf;

  logic          rand_ready = 1'b0, force_ready = 1'b1, chk_en = 1'b0;
  int            n_checks = 0, n_pass = 0;

  // model state: sum/count of the open packet, latched result, beats still owed
  logic [DW-1:0] m_sum = '0, r_sum = '0;
  int            m_cnt = 0, r_cnt = 0, pending = 0;
  logic          m_ovf = 1'b0;
  logic [DW:0]   obs_q[$];

  axis_packet_summer #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .axis_aclk(clk), .axis_areset(rst),
    .s03_axis_rd_tdata(s_data), .s03_axis_tstrb(s_strb),
    .s03_axis_tvalid(s_valid), .s03_axis_tlast(s_last), .s03_axis_tready(s_ready),
    .m03_axis_tdata(m_data), .m03_axis_tstrb(m_strb), .m03_axis_tvalid(m_valid),
    .m03_axis_tlast(m_last), .m03_axis_tready(m_ready),
    .busy(busy), .count_overflow(ovf)
  );

  always #5 clk = ~clk;

  always @(negedge clk) m_ready = rand_ready ? ($urandom_range(0, 3) != 0) : force_ready;

  function automatic logic [DW-1:0] mask_bytes(input logic [DW-1:0] d, input logic [SW-1:0] s);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < SW; i++) if (s[i]) r = r | (d & (DW'(32'hFF) << (8 * i)));
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  always @(posedge clk) begin
    logic acc;
    if (!rst && m_valid && m_ready) obs_q.push_back({m_last, m_data});
    if (rst) begin
      m_sum = '0; m_cnt = 0; m_ovf = 1'b0; pending = 0;
    end else begin
      acc = s_valid && (pending == 0);
      if (pending == 2 && m_ready) pending = 1;
      else if (pending == 1 && m_ready) begin
        pending = 0; m_sum = '0; m_cnt = 0;
      end
      if (acc) begin
        m_sum = m_sum + mask_bytes(s_data, s_strb);
        if (m_cnt == CMAX) m_ovf = 1'b1;
        else m_cnt++;
        if (s_last) begin
          r_sum = m_sum; r_cnt = m_cnt; pending = 2;
        end
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (chk_en) begin
      chk("s_tready", 64'(s_ready), 64'(!rst && pending == 0));
      chk("m_tvalid", 64'(m_valid), 64'(pending != 0));
      chk("m_tdata",  64'(m_data),  (pending == 2) ? 64'(r_sum) : (pending == 1) ? 64'(r_cnt) : 64'd0);
      chk("m_tstrb",  64'(m_strb),  (pending != 0) ? 64'((1 << SW) - 1) : 64'd0);
      chk("m_tlast",  64'(m_last),  64'(pending == 1));
      chk("busy",     64'(busy),    64'(pending != 0 || m_cnt != 0));
      chk("overflow", 64'(ovf),     64'(m_ovf));
    end
  end

  task automatic send_beat(input logic [DW-1:0] d, input logic [SW-1:0] s, input logic l, input int gap);
    bit got = 0;
    repeat (gap) begin
      @(negedge clk);
      s_valid = 1'b0; s_data = $urandom; s_strb = SW'($urandom); s_last = 1'($urandom);
    end
    @(negedge clk);
    s_valid = 1'b1; s_data = d; s_strb = s; s_last = l;
    for (int t = 0; t < 300; t++) begin
      @(posedge clk);
      if (s_ready) begin got = 1; break; end
    end
    if (!got) chk("input_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic stop_in();
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int t = 0; t < 500; t++) begin
      @(posedge clk); #1;
      if (pending == 0) begin done = 1; break; end
    end
    if (!done) chk("result_drain_timeout", 64'd0, 64'd1);
  endtask

  task automatic pulse_reset();
    @(negedge clk); s_valid = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic chk_result(input string name, input logic [DW-1:0] sum_e, input logic [DW-1:0] cnt_e);
    chk({name, "_beats"}, 64'(obs_q.size()), 64'd2);
    if (obs_q.size() >= 2) begin
      chk({name, "_sum"}, 64'(obs_q[0]), 64'({1'b0, sum_e}));
      chk({name, "_cnt"}, 64'(obs_q[1]), 64'({1'b1, cnt_e}));
    end
    obs_q.delete();
  endtask

  initial begin
    int npk;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(negedge clk); rst = 1'b0;
    obs_q.delete();

    send_beat(32'h1, 4'hF, 1'b0, 0);
    send_beat(32'h2, 4'hF, 1'b0, 0);
    send_beat(32'h3, 4'hF, 1'b1, 0);
    stop_in(); wait_idle();
    chk("model_sum_3beat", 64'(r_sum), 64'd6);
    chk("model_cnt_3beat", 64'(r_cnt), 64'd3);
    chk_result("three_beat", 32'h6, 32'h3);

    send_beat(32'hAABBCCDD, 4'h3, 1'b1, 0);
    stop_in(); wait_idle();
    chk("model_sum_mask", 64'(r_sum), 64'h0000CCDD);
    chk_result("mask", 32'h0000CCDD, 32'h1);

    send_beat(32'hFFFFFFFF, 4'hF, 1'b0, 1);
    send_beat(32'h00000002, 4'hF, 1'b1, 0);
    stop_in(); wait_idle();
    chk_result("wrap", 32'h1, 32'h2);
    chk("wrap_no_overflow", 64'(ovf), 64'd0);

    force_ready = 1'b0;
    send_beat(32'h10, 4'hF, 1'b1, 0);
    @(negedge clk);
    s_valid = 1'b1; s_data = 32'h55; s_strb = 4'hF; s_last = 1'b1;
    repeat (4) @(negedge clk);
    chk("stall_tvalid", 64'(m_valid), 64'd1);
    chk("stall_tdata",  64'(m_data),  64'h10);
    chk("stall_s_tready", 64'(s_ready), 64'd0);
    force_ready = 1'b1;
    send_beat(32'h55, 4'hF, 1'b1, 0);
    stop_in(); wait_idle();
    chk("bp_beats", 64'(obs_q.size()), 64'd4);
    if (obs_q.size() == 4) begin
      chk("bp_sum0", 64'(obs_q[0]), 64'({1'b0, 32'h10}));
      chk("bp_cnt0", 64'(obs_q[1]), 64'({1'b1, 32'h1}));
      chk("bp_sum1", 64'(obs_q[2]), 64'({1'b0, 32'h55}));
    end
    obs_q.delete();

    send_beat(32'h5, 4'hF, 1'b0, 0);
    send_beat(32'h6, 4'hF, 1'b0, 0);
    pulse_reset();
    send_beat(32'h7, 4'hF, 1'b1, 0);
    stop_in(); wait_idle();
    chk_result("reset_mid_packet", 32'h7, 32'h1);

    force_ready = 1'b0;
    send_beat(32'h9, 4'hF, 1'b1, 0);
    stop_in();
    repeat (2) @(negedge clk);
    pulse_reset();
    force_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("reset_mid_result_beats", 64'(obs_q.size()), 64'd0);
    chk("reset_mid_result_valid", 64'(m_valid), 64'd0);
    obs_q.delete();

    for (int i = 0; i < 5; i++) send_beat(32'h1, 4'hF, 1'(i == 4), 0);
    stop_in(); wait_idle();
    chk_result("saturate", 32'h5, 32'h3);
    chk("saturate_overflow", 64'(ovf), 64'd1);
    send_beat(32'h10, 4'hF, 1'b1, 0);
    stop_in(); wait_idle();
    chk_result("after_saturate", 32'h10, 32'h1);
    chk("overflow_sticky", 64'(ovf), 64'd1);

    pulse_reset();
    @(posedge clk); #1;
    chk("overflow_cleared", 64'(ovf), 64'd0);

    rand_ready = 1'b1;
    npk = 40;
    for (int p = 0; p < npk; p++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int b = 0; b < len; b++)
        send_beat($urandom, SW'($urandom), 1'(b == len - 1), $urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) stop_in();
    end
    stop_in(); wait_idle();
    chk("random_result_beats", 64'(obs_q.size()), 64'(2 * npk));

    rand_ready = 1'b0;
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
